pcs_10g_tx_gearbox: RTL and testbench

// 66b->64b TX gearbox for the 10GBASE-R PCS, between the TX scrambler and the

---
 rtl/pcs_10g_tx_gearbox.sv | 67 ++++++
 tb/tb_pcs_10g_tx_gearbox.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pcs_10g_tx_gearbox.sv
// pcs_10g_tx_gearbox: 66b->64b TX gearbox packing 32 blocks into 33 words, LSB-first;
// optional idle-block insertion on underflow when PCS_TX_GEARBOX_IDLE_INSERT_EN is defined
module pcs_10g_tx_gearbox #(
    parameter int DATA_W  = 64,
    parameter int HEAD_W  = 2,
    parameter int BLOCK_W = HEAD_W + DATA_W
) (
    input  logic              tx_par_clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] tx_par_data_o,
    output logic [5:0]        seq_o
`ifdef PCS_TX_GEARBOX_IDLE_INSERT_EN
    ,
    output logic              underflow_o
`endif
);
    logic [63:0]        res_q, res_d, tx_q, tx_d;
    logic [5:0]         seq_q, seq_d;
    logic [BLOCK_W-1:0] blk;
    logic [127:0]       wide;
    logic               last;

    assign last          = seq_q == 6'd32;
    assign ready_o       = !reset && !last;
    assign tx_par_data_o = tx_q;
    assign seq_o         = seq_q;

`ifdef PCS_TX_GEARBOX_IDLE_INSERT_EN
    logic uf_q, uf_d;
    assign blk         = valid_i ? {data_i, head_i} : {64'h0000_0000_0000_001E, 2'b10};
    assign uf_d        = ready_o && !valid_i;
    assign underflow_o = uf_q;
    // underflow flag aligned with the output word carrying the idle block
    always_ff @(posedge tx_par_clk) begin
        uf_q <= reset ? 1'b0 : uf_d;
    end
`else
    logic unused_valid;
    assign unused_valid = valid_i;
    assign blk          = {data_i, head_i};
`endif

    // residual occupies the low 2*seq bits; new block lands just above it
    always_comb begin
        wide  = {{(128-BLOCK_W){1'b0}}, blk} << {seq_q, 1'b0};
        tx_d  = last ? res_q : wide[63:0] | res_q;
        res_d = last ? 64'd0 : wide[127:64];
        seq_d = last ? 6'd0 : seq_q + 6'd1;
    end

    // state registers, reset drops any residual bits
    always_ff @(posedge tx_par_clk) begin
        if (reset) begin
            tx_q  <= '0;
            res_q <= '0;
            seq_q <= '0;
        end else begin
            tx_q  <= tx_d;
            res_q <= res_d;
            seq_q <= seq_d;
        end
    end
endmodule

// File: tb/tb_pcs_10g_tx_gearbox.sv
// tb_pcs_10g_tx_gearbox: random blocks checked against a bit-stream reference model via a scoreboard
module tb_pcs_10g_tx_gearbox;
    logic        tx_par_clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [1:0]  head_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic [63:0] tx_par_data_o;
    logic [5:0]  seq_o;
`ifdef PCS_TX_GEARBOX_IDLE_INSERT_EN
    logic        underflow_o;
`endif

    pcs_10g_tx_gearbox dut (
        .tx_par_clk(tx_par_clk),
        .reset(reset),
        .valid_i(valid_i),
        .head_i(head_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .tx_par_data_o(tx_par_data_o),
        .seq_o(seq_o)
`ifdef PCS_TX_GEARBOX_IDLE_INSERT_EN
        ,
        .underflow_o(underflow_o)
`endif
    );

    always #5 tx_par_clk = ~tx_par_clk;

    int          cmp = 0;
    int          err = 0;
    int          k = 0;
    bit          bq[$];
    logic [64:0] exp_q[$];
    logic [64:0] e;
    logic [63:0] last_data;

    function automatic void check(string n, logic [63:0] act, logic [63:0] req);
        cmp++;
        if (act !== req) begin
            err++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endfunction

    // one cycle from negedge to negedge; model = stream of accepted bits, 64 drained per cycle
    task automatic step(input logic [1:0] h, input logic [63:0] d, input bit v);
        logic [65:0] b;
        logic [63:0] w;
        bit          uf;
        head_i  = h;
        data_i  = d;
        valid_i = v;
        #1;
        check("ready", 64'(ready_o), 64'(k != 32));
        check("seq", 64'(seq_o), 64'(k));
        uf = 1'b0;
        if (k != 32) begin
            b = {d, h};
`ifdef PCS_TX_GEARBOX_IDLE_INSERT_EN
            if (!v) begin
                b  = {64'h0000_0000_0000_001E, 2'b10};
                uf = 1'b1;
            end
`endif
            for (int i = 0; i < 66; i++) bq.push_back(b[i]);
            if (k == 31) last_data = b[65:2];
        end
        for (int i = 0; i < 64; i++) w[i] = bq.pop_front();
        exp_q.push_back({uf, w});
        k = (k == 32) ? 0 : k + 1;
        @(negedge tx_par_clk);
    endtask

    task automatic rstep(input bit v);
        step(2'($urandom_range(0, 3)), {$urandom, $urandom}, v);
    endtask

    // monitor: one output word per cycle, compared against the scoreboard
    initial forever begin
        @(posedge tx_par_clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("word", e[63:0] ^ e[63:0] | tx_par_data_o, e[63:0]);
`ifdef PCS_TX_GEARBOX_IDLE_INSERT_EN
            check("underflow", 64'(underflow_o), 64'(e[64]));
`endif
        end
    end

    initial begin
        int p;
        reset   = 1'b1;
        valid_i = 1'b1;
        head_i  = '0;
        data_i  = '0;
        repeat (3) @(posedge tx_par_clk);
        #1;
        check("rst_data", tx_par_data_o, 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_seq", 64'(seq_o), 64'd0);
        @(negedge tx_par_clk);
        reset = 1'b0;
        #1;
        check("rel_ready", 64'(ready_o), 64'd1);
        check("rel_seq", 64'(seq_o), 64'd0);
        step(2'b01, 64'h0123_4567_89AB_CDEF, 1'b1);
        check("t2_word", tx_par_data_o, 64'h048D_159E_26AF_37BD);
        check("t2_seq", 64'(seq_o), 64'd1);
        for (int s = 1; s < 99; s++) begin
            p = k;
            rstep(!(s < 33 && p == 5));
            if (p == 32) check("t3_word", tx_par_data_o, last_data);
            if (p == 32) check("t3_seq", 64'(seq_o), 64'd0);
`ifdef PCS_TX_GEARBOX_IDLE_INSERT_EN
            if (s < 33 && p == 5) check("t6_underflow", 64'(underflow_o), 64'd1);
`endif
        end
        while (k != 17) rstep(1'b1);
        reset = 1'b1;
        #1;
        check("t5_ready", 64'(ready_o), 64'd0);
        bq.delete();
        exp_q.push_back(65'd0);
        k = 0;
        @(negedge tx_par_clk);
        check("t5_seq0", 64'(seq_o), 64'd0);
        reset = 1'b0;
        step(2'b01, 64'h0123_4567_89AB_CDEF, 1'b1);
        check("t5_word", tx_par_data_o, 64'h048D_159E_26AF_37BD);
        for (int s = 0; s < 40; s++) rstep(1'b1);
        @(negedge tx_par_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
